// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: forwarding-select
//   encodings, the "source unused" tuse value, and tnew/tuse/MDU-counter widths.
package hazard_ctrl_pkg;

    localparam int unsigned TNEW_W   = 2;
    localparam int unsigned TUSE_W   = 2;
    localparam int unsigned MD_CNT_W = 4;

    // A tuse of 3 marks a source operand the instruction does not read.
    localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

    // Forwarding mux selects, ordered by producer age (E is youngest).
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2,
        FWD_E  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// md_busy_cnt
//   Tracks the remaining busy cycles of the multiply/divide unit.
//   Ports:
//     clk      - clock, rising edge
//     reset_n  - synchronous active-low reset, clears the counter
//     start_i  - MDU operation enters E this cycle (reloads the counter)
//     div_i    - 1 = divide, 0 = multiply (selects the reload value)
//     busy_o   - counter nonzero, or an operation is starting now
module md_busy_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_i,
    input  logic div_i,
    output logic busy_o
);

    logic [MD_CNT_W-1:0] cnt_q, cnt_d;

    // A new start always reloads, so the latest operation wins.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = div_i ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - MD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // While reset is held the counter is treated as zero, so busy only
    // reflects a start arriving in that same cycle.
    assign busy_o = (reset_n && (cnt_q != '0)) || start_i;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard unit: data-hazard stall, D/E/M forwarding selects and
//   MDU busy stall for a 5-stage pipeline.
//   Ports:
//     clk, reset_n                 - clock and synchronous active-low reset
//     d_rs/d_rt, d_*_tuse          - D-stage sources and cycles until use (3 = unused)
//     e_rs/e_rt, e_*_use           - E-stage sources and their use flags
//     m_rt, m_rt_use               - M-stage store-data source
//     e_wr/m_wr/w_wr               - destination registers (0 = no write)
//     e_tnew/m_tnew                - cycles until the E/M result is ready
//     e_md_start, e_md_div         - MDU op enters E; 1 = divide
//     d_md_use                     - D instruction needs HI/LO or the MDU
//     stall                        - freeze F/D, bubble into E
//     fwd_d_rs/rt, fwd_e_rs/rt     - 0 = RF, 1 = W, 2 = M, 3 = E
//     fwd_m_rt                     - 1 = W result into M store data
//     md_busy                      - MDU in progress
//     stall_cnt                    - stall-cycle counter (only with HAZARD_STALL_CNT_EN)
//   Optional feature macro: HAZARD_STALL_CNT_EN
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [TUSE_W-1:0] d_rs_tuse,
    input  logic [TUSE_W-1:0] d_rt_tuse,
    input  logic [REG_AW-1:0] e_rs,
    input  logic [REG_AW-1:0] e_rt,
    input  logic              e_rs_use,
    input  logic              e_rt_use,
    input  logic [REG_AW-1:0] m_rt,
    input  logic              m_rt_use,
    input  logic [REG_AW-1:0] e_wr,
    input  logic [REG_AW-1:0] m_wr,
    input  logic [REG_AW-1:0] w_wr,
    input  logic [TNEW_W-1:0] e_tnew,
    input  logic [TNEW_W-1:0] m_tnew,
    input  logic              e_md_start,
    input  logic              e_md_div,
    input  logic              d_md_use,
    output logic              stall,
    output logic [1:0]        fwd_d_rs,
    output logic [1:0]        fwd_d_rt,
    output logic [1:0]        fwd_e_rs,
    output logic [1:0]        fwd_e_rt,
    output logic              fwd_m_rt,
    output logic              md_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    // D source stalls when a producer in E or M will not be ready in time.
    function automatic logic d_hazard(
        input logic [REG_AW-1:0] a,
        input logic [TUSE_W-1:0] tuse,
        input logic [REG_AW-1:0] ewr,
        input logic [TNEW_W-1:0] etn,
        input logic [REG_AW-1:0] mwr,
        input logic [TNEW_W-1:0] mtn
    );
        return (tuse != TUSE_NONE) && (a != '0) &&
               (((a == ewr) && (tuse < etn)) || ((a == mwr) && (tuse < mtn)));
    endfunction

    // Youngest ready producer wins; W is always ready.
    function automatic fwd_sel_e pick_fwd(
        input logic              live,
        input logic              use_e,
        input logic [REG_AW-1:0] a,
        input logic [REG_AW-1:0] ewr,
        input logic [TNEW_W-1:0] etn,
        input logic [REG_AW-1:0] mwr,
        input logic [TNEW_W-1:0] mtn,
        input logic [REG_AW-1:0] wwr
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (live && (a != '0)) begin
            if (use_e && (a == ewr) && (etn == '0)) begin
                sel = FWD_E;
            end else if ((a == mwr) && (mtn == '0)) begin
                sel = FWD_M;
            end else if (a == wwr) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    logic stall_data;
    logic stall_md;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (e_md_start),
        .div_i   (e_md_div),
        .busy_o  (md_busy)
    );

    always_comb begin
        stall_data = d_hazard(d_rs, d_rs_tuse, e_wr, e_tnew, m_wr, m_tnew) ||
                     d_hazard(d_rt, d_rt_tuse, e_wr, e_tnew, m_wr, m_tnew);
        stall_md   = d_md_use && md_busy;
        stall      = stall_data || stall_md;
    end

    // E-stage selects never consider E itself (use_e = 0).
    always_comb begin
        fwd_d_rs = pick_fwd(d_rs_tuse != TUSE_NONE, 1'b1, d_rs, e_wr, e_tnew, m_wr, m_tnew, w_wr);
        fwd_d_rt = pick_fwd(d_rt_tuse != TUSE_NONE, 1'b1, d_rt, e_wr, e_tnew, m_wr, m_tnew, w_wr);
        fwd_e_rs = pick_fwd(e_rs_use, 1'b0, e_rs, e_wr, e_tnew, m_wr, m_tnew, w_wr);
        fwd_e_rt = pick_fwd(e_rt_use, 1'b0, e_rt, e_wr, e_tnew, m_wr, m_tnew, w_wr);
        fwd_m_rt = m_rt_use && (m_rt != '0) && (m_rt == w_wr);
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl: a table of combinational vectors plus
//   hand-written multi-cycle MDU and reset sequences. Expected results are
//   queued when stimulus is driven and compared when the outputs are sampled.
//   Honours HAZARD_STALL_CNT_EN when the RTL is built with it.
module tb_hazard_ctrl;

    localparam int unsigned AW = 5;

    typedef struct {
        logic          reset_n;
        logic [AW-1:0] d_rs, d_rt;
        logic [1:0]    d_rs_tuse, d_rt_tuse;
        logic [AW-1:0] e_rs, e_rt;
        logic          e_rs_use, e_rt_use;
        logic [AW-1:0] m_rt;
        logic          m_rt_use;
        logic [AW-1:0] e_wr, m_wr, w_wr;
        logic [1:0]    e_tnew, m_tnew;
        logic          e_md_start, e_md_div, d_md_use;
    } vin_t;

    typedef struct {
        logic       stall;
        logic [1:0] fdrs, fdrt, fers, fert;
        logic       fmrt;
        logic       busy;
        string      tag;
    } exp_t;

    typedef struct {
        vin_t in;
        exp_t ex;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] d_rs, d_rt, e_rs, e_rt, m_rt, e_wr, m_wr, w_wr;
    logic [1:0]    d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
    logic          e_rs_use, e_rt_use, m_rt_use, e_md_start, e_md_div, d_md_use;
    logic          stall, fwd_m_rt, md_busy;
    logic [1:0]    fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;
    exp_t        exp_q[$];
    rec_t        tbl[14];

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_AW      (AW),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_rs_tuse  (d_rs_tuse),
        .d_rt_tuse  (d_rt_tuse),
        .e_rs       (e_rs),
        .e_rt       (e_rt),
        .e_rs_use   (e_rs_use),
        .e_rt_use   (e_rt_use),
        .m_rt       (m_rt),
        .m_rt_use   (m_rt_use),
        .e_wr       (e_wr),
        .m_wr       (m_wr),
        .w_wr       (w_wr),
        .e_tnew     (e_tnew),
        .m_tnew     (m_tnew),
        .e_md_start (e_md_start),
        .e_md_div   (e_md_div),
        .d_md_use   (d_md_use),
        .stall      (stall),
        .fwd_d_rs   (fwd_d_rs),
        .fwd_d_rt   (fwd_d_rt),
        .fwd_e_rs   (fwd_e_rs),
        .fwd_e_rt   (fwd_e_rt),
        .fwd_m_rt   (fwd_m_rt),
        .md_busy    (md_busy)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    function automatic vin_t idle();
        vin_t v;
        v.reset_n = 1'b1;
        v.d_rs = '0; v.d_rt = '0; v.d_rs_tuse = 2'd3; v.d_rt_tuse = 2'd3;
        v.e_rs = '0; v.e_rt = '0; v.e_rs_use = 1'b0; v.e_rt_use = 1'b0;
        v.m_rt = '0; v.m_rt_use = 1'b0;
        v.e_wr = '0; v.m_wr = '0; v.w_wr = '0; v.e_tnew = '0; v.m_tnew = '0;
        v.e_md_start = 1'b0; v.e_md_div = 1'b0; v.d_md_use = 1'b0;
        return v;
    endfunction

    function automatic exp_t ex(input logic s, input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] c, input logic [1:0] d, input logic m,
                                input logic bz, input string tag);
        exp_t e;
        e.stall = s; e.fdrs = a; e.fdrt = b; e.fers = c; e.fert = d;
        e.fmrt = m; e.busy = bz; e.tag = tag;
        return e;
    endfunction

    task automatic apply(input vin_t v);
        reset_n = v.reset_n;
        d_rs = v.d_rs; d_rt = v.d_rt; d_rs_tuse = v.d_rs_tuse; d_rt_tuse = v.d_rt_tuse;
        e_rs = v.e_rs; e_rt = v.e_rt; e_rs_use = v.e_rs_use; e_rt_use = v.e_rt_use;
        m_rt = v.m_rt; m_rt_use = v.m_rt_use;
        e_wr = v.e_wr; m_wr = v.m_wr; w_wr = v.w_wr; e_tnew = v.e_tnew; m_tnew = v.m_tnew;
        e_md_start = v.e_md_start; e_md_div = v.e_md_div; d_md_use = v.d_md_use;
    endtask

    task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            cmp({e.tag, ".stall"},    {1'b0, stall},    {1'b0, e.stall});
            cmp({e.tag, ".fwd_d_rs"}, fwd_d_rs,         e.fdrs);
            cmp({e.tag, ".fwd_d_rt"}, fwd_d_rt,         e.fdrt);
            cmp({e.tag, ".fwd_e_rs"}, fwd_e_rs,         e.fers);
            cmp({e.tag, ".fwd_e_rt"}, fwd_e_rt,         e.fert);
            cmp({e.tag, ".fwd_m_rt"}, {1'b0, fwd_m_rt}, {1'b0, e.fmrt});
            cmp({e.tag, ".md_busy"},  {1'b0, md_busy},  {1'b0, e.busy});
        end
    endtask

    // Drive one cycle just after the rising edge, sample at the falling edge.
    task automatic step(input vin_t v, input exp_t e);
        @(posedge clk);
        #1;
        apply(v);
        exp_q.push_back(e);
        @(negedge clk);
        check_pop();
    endtask

    // Idle-input cycle where only MDU/reset controls vary.
    task automatic mstep(input logic rn, input logic st, input logic dv, input logic use_md,
                         input logic s, input logic bz, input string tag);
        vin_t v;
        v = idle();
        v.reset_n = rn; v.e_md_start = st; v.e_md_div = dv; v.d_md_use = use_md;
        step(v, ex(s, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, bz, tag));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 14; i++) tbl[i].in = idle();
        tbl[0].ex = ex(0, 0, 0, 0, 0, 0, 0, "idle");
        tbl[1].in.e_wr = 8; tbl[1].in.e_tnew = 2; tbl[1].in.d_rs = 8; tbl[1].in.d_rs_tuse = 1;
        tbl[1].ex = ex(1, 0, 0, 0, 0, 0, 0, "load_use");
        tbl[2].in.e_wr = 8; tbl[2].in.e_tnew = 2; tbl[2].in.d_rs = 0; tbl[2].in.d_rs_tuse = 1;
        tbl[2].ex = ex(0, 0, 0, 0, 0, 0, 0, "load_use_r0");
        tbl[3].in.e_wr = 8; tbl[3].in.e_tnew = 1; tbl[3].in.d_rs = 8; tbl[3].in.d_rs_tuse = 1;
        tbl[3].ex = ex(0, 0, 0, 0, 0, 0, 0, "tuse_eq_tnew");
        tbl[4].in.e_wr = 9; tbl[4].in.m_wr = 9; tbl[4].in.w_wr = 9; tbl[4].in.e_tnew = 1;
        tbl[4].in.m_tnew = 0; tbl[4].in.d_rt = 9; tbl[4].in.d_rt_tuse = 0;
        tbl[4].ex = ex(1, 0, 2, 0, 0, 0, 0, "prio_stall");
        tbl[5].in.m_wr = 9; tbl[5].in.w_wr = 9; tbl[5].in.m_tnew = 0;
        tbl[5].in.d_rt = 9; tbl[5].in.d_rt_tuse = 0;
        tbl[5].ex = ex(0, 0, 2, 0, 0, 0, 0, "prio_advanced");
        tbl[6].in.e_wr = 5; tbl[6].in.e_tnew = 0; tbl[6].in.m_wr = 5; tbl[6].in.w_wr = 5;
        tbl[6].in.d_rs = 5; tbl[6].in.d_rs_tuse = 0;
        tbl[6].ex = ex(0, 3, 0, 0, 0, 0, 0, "fwd_from_e");
        tbl[7].in.w_wr = 7; tbl[7].in.d_rs = 7; tbl[7].in.d_rs_tuse = 2;
        tbl[7].in.d_rt = 7; tbl[7].in.d_rt_tuse = 3;
        tbl[7].ex = ex(0, 1, 0, 0, 0, 0, 0, "fwd_from_w");
        tbl[8].in.m_wr = 6; tbl[8].in.m_tnew = 1; tbl[8].in.d_rs = 6; tbl[8].in.d_rs_tuse = 0;
        tbl[8].ex = ex(1, 0, 0, 0, 0, 0, 0, "m_not_ready");
        tbl[9].in.e_wr = 4; tbl[9].in.e_tnew = 0; tbl[9].in.m_wr = 4; tbl[9].in.w_wr = 4;
        tbl[9].in.e_rs = 4; tbl[9].in.e_rs_use = 1; tbl[9].in.e_rt = 4; tbl[9].in.e_rt_use = 0;
        tbl[9].ex = ex(0, 0, 0, 2, 0, 0, 0, "e_fwd_m");
        tbl[10].in.m_wr = 3; tbl[10].in.m_tnew = 1; tbl[10].in.w_wr = 3;
        tbl[10].in.e_rs = 3; tbl[10].in.e_rs_use = 1; tbl[10].in.e_rt = 0; tbl[10].in.e_rt_use = 1;
        tbl[10].in.m_rt = 3; tbl[10].in.m_rt_use = 1;
        tbl[10].ex = ex(0, 0, 0, 1, 0, 1, 0, "e_fwd_w");
        tbl[11].in.m_rt = 3; tbl[11].in.m_rt_use = 0; tbl[11].in.w_wr = 3;
        tbl[11].in.e_rt = 3; tbl[11].in.e_rt_use = 1;
        tbl[11].ex = ex(0, 0, 0, 0, 1, 0, 0, "m_rt_unused");
        tbl[12].in.d_md_use = 1;
        tbl[12].ex = ex(0, 0, 0, 0, 0, 0, 0, "md_use_idle");
        tbl[13].in.e_wr = 10; tbl[13].in.e_tnew = 2; tbl[13].in.d_rs = 10; tbl[13].in.d_rs_tuse = 3;
        tbl[13].ex = ex(0, 0, 0, 0, 0, 0, 0, "src_unused");

        apply(idle());
        reset_n = 1'b0;
        mstep(0, 0, 0, 0, 0, 0, "reset0");
        mstep(0, 1, 1, 0, 0, 1, "reset_start");
        mstep(1, 0, 0, 1, 0, 0, "after_reset");

        for (int i = 0; i < 14; i++) step(tbl[i].in, tbl[i].ex);

        // Divide with D waiting on the MDU: 10 stall cycles, clear on the 11th.
        mstep(1, 1, 1, 0, 0, 1, "div_start");
        for (int k = 1; k <= 11; k++)
            mstep(1, 0, 0, 1, (k <= 10), (k <= 10), $sformatf("div_c%0d", k));

        // Multiply with D using the MDU in the start cycle.
        mstep(1, 1, 0, 1, 1, 1, "mul_start");
        for (int k = 1; k <= 6; k++)
            mstep(1, 0, 0, 1, (k <= 5), (k <= 5), $sformatf("mul_c%0d", k));

        // Multiply issued mid-divide reloads: latest operation wins.
        mstep(1, 1, 1, 0, 0, 1, "rl_div");
        mstep(1, 0, 0, 0, 0, 1, "rl_c1");
        mstep(1, 0, 0, 0, 0, 1, "rl_c2");
        mstep(1, 1, 0, 1, 1, 1, "rl_mul");
        for (int k = 1; k <= 6; k++)
            mstep(1, 0, 0, 1, (k <= 5), (k <= 5), $sformatf("rl_m%0d", k));

        // Reset mid-divide.
        mstep(1, 1, 1, 1, 1, 1, "rst_div");
        mstep(1, 0, 0, 1, 1, 1, "rst_c1");
        mstep(1, 0, 0, 1, 1, 1, "rst_c2");
        mstep(0, 0, 0, 1, 0, 0, "rst_c3");
        mstep(1, 0, 0, 1, 0, 0, "rst_c4");

`ifdef HAZARD_STALL_CNT_EN
        mstep(0, 0, 0, 0, 0, 0, "cnt_reset");
        for (int k = 0; k < 7; k++) step(tbl[1].in, tbl[1].ex);
        mstep(1, 0, 0, 0, 0, 0, "cnt_idle");
        cmp("stall_cnt_lo", stall_cnt[1:0], 2'd3);
        checks++;
        if (stall_cnt !== 32'd7) begin
            failures++;
            $display("FAIL stall_cnt: got %0d expected 7", stall_cnt);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter MULT_CYCLES, default 5: multiply busy cycles, range 1..15.
REQ-003 Parameter DIV_CYCLES, default 10: divide busy cycles, range 1..15.
REQ-004 clk  in  1: sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1: synchronous, active-low reset.
REQ-006 d_rs, d_rt  in  REG_AW each: D-stage source register addresses.
REQ-007 d_rs_tuse, d_rt_tuse  in  2 each: cycles until D-stage use; 3 means the source is unused.
REQ-008 e_rs, e_rt  in  REG_AW each: E-stage source register addresses.
REQ-009 e_rs_use, e_rt_use  in  1 each: E stage reads that source.
REQ-010 m_rt, m_rt_use  in  REG_AW, 1: M-stage store-data source.
REQ-011 e_wr, m_wr, w_wr  in  REG_AW each: destination addresses; 0 means no write.
REQ-012 e_tnew, m_tnew  in  2 each: cycles until the result is ready in that stage.
REQ-013 e_md_start, e_md_div  in  1, 1: MDU operation enters E; 1 = divide.
REQ-014 d_md_use  in  1: D instruction touches HI/LO or the MDU.
REQ-015 stall  out  1: freeze F/D, bubble into E.
REQ-016 fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt  out  2 each: 0 = register file, 1 = W, 2 = M, 3 = E.
REQ-017 fwd_m_rt  out  1: 1 = W result into the M store data.
REQ-018 md_busy  out  1: MDU in progress.

Function
REQ-019 Data-hazard stall SHALL assert when a D source with tuse != 3 and address != 0 matches e_wr and tuse < e_tnew, or matches m_wr and tuse < m_tnew.
REQ-020 A D/E forward SHALL select the youngest matching stage with tnew == 0 and a nonzero address; priority is E(3) > M(2) > W(1). W is always ready.
REQ-021 E forwarding SHALL consider only M and W; fwd_e_* SHALL never be 3. Any select SHALL be 0 when its use flag is low or tuse == 3.
REQ-022 A 4-bit MDU counter SHALL load MULT_CYCLES or DIV_CYCLES on e_md_start and otherwise decrement to 0, saturating at 0.
REQ-023 md_busy SHALL equal (counter != 0) | e_md_start.
REQ-024 MDU stall SHALL assert when d_md_use and md_busy are both high.
REQ-025 stall SHALL be the OR of the data and MDU stalls; it is combinational and has zero-cycle latency.
REQ-026 e_md_start while the counter is nonzero SHALL reload the counter, so the latest operation wins.
REQ-027 The cycle the counter reaches 0 SHALL be the first cycle without the MDU stall.

Reset
REQ-028 When reset_n is low at a clock edge, the MDU counter SHALL clear to 0 and the stall counter SHALL clear, including mid-operation.
REQ-029 During reset, outputs SHALL follow their combinational inputs with counter = 0; md_busy SHALL be low unless e_md_start is high.

Configuration
REQ-030 With macro HAZARD_STALL_CNT_EN defined, a 32-bit output stall_cnt SHALL increment on every clock with stall high, wrapping at 2^32.
REQ-031 Without HAZARD_STALL_CNT_EN, the stall_cnt port and its register SHALL be absent.

Structure
REQ-032 A shared package SHALL hold the forwarding-select encodings, the TUSE_NONE = 3 constant and the tnew/tuse widths.
REQ-033 The MDU busy counter SHALL be a sub-module, md_busy_cnt.

Verification
REQ-034 Load-use: e_wr=8, e_tnew=2, d_rs=8, d_rs_tuse=1 -> stall=1.
REQ-035 Same as REQ-034 but with d_rs=0 -> stall=0 and fwd_d_rs=0.
REQ-036 Priority: e_wr=m_wr=w_wr=9, e_tnew=1, m_tnew=0, d_rt=9, d_rt_tuse=0 -> stall=1. After E advances (m_wr=9, m_tnew=0) -> stall=0, fwd_d_rt=2.
REQ-037 Div: e_md_start=1, e_md_div=1, then d_md_use=1 held -> stall high for 10 cycles, low on the 11th.
REQ-038 Reset mid-divide: reset_n low at cycle 3 -> next cycle md_busy=0 and stall=0.
REQ-039 With HAZARD_STALL_CNT_EN: 7 stall cycles -> stall_cnt=7. Start at 0xFFFFFFFF with one stall -> stall_cnt=0.
